// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep checker for a single-output combinational block.
// Optional TT_SWEEP_GRAY_ORDER_EN applies vectors in Gray-code order.
module tt_sweep_checker #(
    parameter int N_IN = 3,
    parameter int HOLD = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 8'hE8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'((1 << N_IN) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [N_IN-1:0] idx;
    logic [HW-1:0]   hold;
    logic            sample;
    logic            last;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] i);
`ifdef TT_SWEEP_GRAY_ORDER_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // Sample in the last cycle of each hold window, against the applied vector.
    assign sample   = (state == S_DRIVE) && (hold == '0);
    assign last     = (idx == IDX_LAST);
    assign mismatch = sample && (dut_out != EXPECT[dut_in]);
    assign err_next = err_cnt + {{N_IN{1'b0}}, mismatch};

    assign busy = (state == S_DRIVE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_DRIVE;
            S_DRIVE: if (sample && last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            hold       <= '0;
            dut_in     <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                        idx        <= '0;
                        hold       <= HOLD_LAST;
                        dut_in     <= map_vec('0);
                    end
                end
                S_DRIVE: begin
                    if (hold != '0) begin
                        hold <= hold - 1'b1;
                    end else begin
                        if (mismatch) begin
                            err_cnt <= err_next;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                first_fail <= dut_in;
                            end
                        end
                        if (last) begin
                            pass <= (err_next == '0);
                        end else begin
                            idx    <= idx + 1'b1;
                            hold   <= HOLD_LAST;
                            dut_in <= map_vec(idx + 1'b1);
                        end
                    end
                end
                S_DONE: begin
                    dut_in <= '0;
                end
                default: begin
                    dut_in <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: random DUT truth tables vs reference model.
// Build with TT_SWEEP_GRAY_ORDER_EN to expect Gray-code vector order.
module tb_tt_sweep_checker;

    localparam int N = 3;
    localparam int H = 2;
    localparam int NV = 1 << N;
    localparam logic [NV-1:0] EXP = 8'hE8;

    typedef struct {
        logic [N:0]          err;
        logic                fv;
        logic [N-1:0]        ff;
        logic                pass;
        int                  done_cyc;
        logic [NV-1:0][N-1:0] seq;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          dut_out;
    logic [N-1:0]  dut_in;
    logic          busy;
    logic          done;
    logic          pass;
    logic [N:0]    err_cnt;
    logic          fail_valid;
    logic [N-1:0]  first_fail;

    logic [NV-1:0] model = EXP;
    exp_t          sb[$];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    int            busy_run = 0;
    int            seq_err = 0;

    assign dut_out = model[dut_in];

    tt_sweep_checker #(.N_IN(N), .HOLD(H), .EXPECT(EXP)) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dut_out(dut_out),
        .dut_in(dut_in),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_cnt(err_cnt),
        .fail_valid(fail_valid),
        .first_fail(first_fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Application order and expected results from the truth tables alone.
    function automatic exp_t ref_model(input logic [NV-1:0] m, input int dc);
        exp_t e;
        int   q[$];
        int   n;
        q.push_back(0);
        for (int b = 0; b < N; b++) begin
            n = q.size();
`ifdef TT_SWEEP_GRAY_ORDER_EN
            for (int i = n - 1; i >= 0; i--) q.push_back(q[i] + (1 << b));
`else
            for (int i = 0; i < n; i++) q.push_back(q[i] + (1 << b));
`endif
        end
        e.err = '0;
        e.fv = 1'b0;
        e.ff = '0;
        e.done_cyc = dc;
        for (int i = 0; i < NV; i++) begin
            e.seq[i] = N'(q[i]);
            if (m[q[i]] != EXP[q[i]]) begin
                e.err = e.err + 1'b1;
                if (!e.fv) begin
                    e.fv = 1'b1;
                    e.ff = N'(q[i]);
                end
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    // Monitor: checks the applied sequence and pops one result per done pulse.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            busy_run = 0;
            seq_err = 0;
        end else begin
            if (busy) begin
                if (sb.size() > 0 && busy_run < NV * H) begin
                    if (dut_in != sb[0].seq[busy_run / H]) seq_err++;
                end
                busy_run++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("err_cnt", int'(err_cnt), int'(e.err));
                    chk("fail_valid", int'(fail_valid), int'(e.fv));
                    chk("first_fail", int'(first_fail), int'(e.ff));
                    chk("pass", int'(pass), int'(e.pass));
                    chk("busy_len", busy_run, NV * H);
                    chk("seq_err", seq_err, 0);
                    chk("done_cycle", cyc, e.done_cyc);
                end
                busy_run = 0;
                seq_err = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vec(input logic [N-1:0] v);
        int n = 0;
        while (!(busy && dut_in == v) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("wait_vec_timeout", 1, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
        chk({tag, "_fail_valid"}, int'(fail_valid), 0);
        chk({tag, "_first_fail"}, int'(first_fail), 0);
        chk({tag, "_dut_in"}, int'(dut_in), 0);
    endtask

    // mode 0: plain sweep, 1: start pulse at vector 2, 2: reset at vector 4
    task automatic run_sweep(input logic [NV-1:0] m, input int mode);
        int n = 0;
        while ((busy || done) && n < 40) begin
            tick();
            n++;
        end
        model = m;
        sb.push_back(ref_model(m, cyc + 17));
        start = 1'b1;
        tick();
        start = 1'b0;
        if (mode == 1) begin
            wait_vec(N'(2));
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (mode == 2) begin
            wait_vec(N'(4));
            #2;
            rst_n = 1'b0;
            #1;
            check_zero("midrst");
            void'(sb.pop_back());
            tick();
            rst_n = 1'b1;
            return;
        end
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("done_timeout", 1, 0);
        tick();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_zero("reset");
        tick();
        run_sweep(EXP, 0);
        run_sweep(EXP ^ 8'h20, 0);
        run_sweep('0, 0);
        run_sweep(EXP, 0);
        run_sweep(EXP, 1);
        run_sweep(EXP ^ 8'h01, 2);
        run_sweep(8'hFF, 0);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) run_sweep(NV'($urandom_range(0, 255)), 0);
            else run_sweep(EXP ^ NV'(1 << $urandom_range(0, 7)), 0);
        end
        // Start held high: second sweep begins in the first IDLE cycle after DONE.
        model = EXP ^ 8'h80;
        sb.push_back(ref_model(model, cyc + 17));
        sb.push_back(ref_model(model, cyc + 35));
        start = 1'b1;
        n = 0;
        while (cyc < sb[sb.size()-1].done_cyc && n < 60) begin
            tick();
            n++;
        end
        start = 1'b0;
        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        chk("idle_pass_hold", int'(pass), 0);
        chk("idle_err_hold", int'(err_cnt), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
